spi_mnrch_param: RTL and testbench

- Parametrised SPI monarch: one serial transaction per wrt pulse to one of NUM_SS serfs.
- Adds runtime SPI mode (CPOL/CPHA), per-transaction frame length and multi-serf select.
- Adds a held read-data register, replacing a live shift-register view.
- Sits between command sequencers (inertial sensor, A2D) and the off-chip SPI pins.

---
 rtl/spi_mnrch_pkg.sv | 26 ++
 rtl/spi_mnrch_if.sv | 35 +++
 rtl/spi_sclk_gen.sv | 60 ++++++
 rtl/spi_mnrch_param.sv | 150 +++++++++++++++
 tb/tb_spi_mnrch_param.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_mnrch_pkg.sv
// Shared types, state constants and width helpers for the parametrised SPI monarch.
package spi_mnrch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRONT = 2'd1,
        XFER  = 2'd2,
        BACK  = 2'd3
    } state_t;

    // Plain-vector aliases of the enum for the legacy-style state register
    localparam logic [1:0] S_IDLE  = 2'(IDLE);
    localparam logic [1:0] S_FRONT = 2'(FRONT);
    localparam logic [1:0] S_XFER  = 2'(XFER);
    localparam logic [1:0] S_BACK  = 2'(BACK);

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_mnrch_if.sv
// Command-side bus of the SPI monarch (sequencer <-> monarch).
// SPI_MNRCH_LSB_FIRST_EN adds the lsb_first request bit.
interface spi_mnrch_if import spi_mnrch_pkg::*; #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NUM_SS = 1
) ();

    localparam int unsigned LEN_W = $clog2(DATA_W);
    localparam int unsigned SEL_W = clog2_min1(NUM_SS);

    logic              wrt;
    logic [DATA_W-1:0] wt_data;
    logic [LEN_W-1:0]  len;
    spi_mode_t         mode;
    logic [SEL_W-1:0]  ss_sel;
`ifdef SPI_MNRCH_LSB_FIRST_EN
    logic              lsb_first;
`endif
    logic [DATA_W-1:0] rd_data;
    logic              busy;
    logic              done;

`ifdef SPI_MNRCH_LSB_FIRST_EN
    modport master (output wrt, wt_data, len, mode, ss_sel, lsb_first,
                    input  rd_data, busy, done);
    modport slave  (input  wrt, wt_data, len, mode, ss_sel, lsb_first,
                    output rd_data, busy, done);
`else
    modport master (output wrt, wt_data, len, mode, ss_sel,
                    input  rd_data, busy, done);
    modport slave  (input  wrt, wt_data, len, mode, ss_sel,
                    output rd_data, busy, done);
`endif

endinterface

// File: rtl/spi_sclk_gen.sv
// SCLK divider: per-phase counter, sample/shift/porch strobes and the registered SCLK level.
module spi_sclk_gen import spi_mnrch_pkg::*; #(
    parameter int unsigned DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] state,
    input  logic       last_bit,
    input  spi_mode_t  mode,
    output logic       smpl_c,
    output logic       shft_c,
    output logic       porch_end_c,
    output logic       sclk
);

    localparam int unsigned     CNT_W    = $clog2(DIV);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_END = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             in_xfer_c;
    logic             in_porch_c;
    logic             lead_c;

    assign in_xfer_c   = (state == S_XFER);
    assign in_porch_c  = (state == S_FRONT) || (state == S_BACK);
    assign smpl_c      = in_xfer_c && (cnt == HALF_END);
    assign shft_c      = in_xfer_c && (cnt == FULL_END);
    assign porch_end_c = in_porch_c && (cnt == HALF_END);
    // Level of the first half of every bit period
    assign lead_c      = mode.cpha ? ~mode.cpol : mode.cpol;

    // Bit periods wrap naturally because DIV is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (state == S_IDLE || porch_end_c)
            cnt <= '0;
        else
            cnt <= cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk <= 1'b0;
        end else begin
            case (state)
                S_XFER: begin
                    if (smpl_c)
                        sclk <= ~lead_c;
                    else if (shft_c)
                        sclk <= last_bit ? mode.cpol : lead_c;
                end
                S_FRONT: sclk <= porch_end_c ? lead_c : mode.cpol;
                default: sclk <= mode.cpol;
            endcase
        end
    end

endmodule

// File: rtl/spi_mnrch_param.sv
// Parametrised SPI monarch: one frame per accepted wrt, runtime mode/length/serf select.
// SPI_MNRCH_LSB_FIRST_EN enables the per-frame LSB-first option.
module spi_mnrch_param import spi_mnrch_pkg::*; #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NUM_SS = 1,
    parameter int unsigned DIV    = 16
) (
    input  logic              clk,
    input  logic              rst,
    spi_mnrch_if.slave        bus,
    input  logic              MISO,
    output logic [NUM_SS-1:0] SS_n,
    output logic              SCLK,
    output logic              MOSI
);

    localparam int unsigned LEN_W = $clog2(DATA_W);

    logic [1:0]        state;
    logic [1:0]        state_d;
    logic [DATA_W-1:0] tx_q;
    logic [DATA_W-1:0] rx_sr;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  bit_cnt;
    spi_mode_t         mode_q;
    spi_mode_t         mode_d;
    logic              lsb_q;
    logic              lsb_d;
    logic              miso_smpl;
    logic [DATA_W-1:0] rd_q;
    logic              busy_q;
    logic              done_q;

    logic              accept_c;
    logic              last_bit_c;
    logic              smpl_c;
    logic              shft_c;
    logic              porch_end_c;
    logic [LEN_W-1:0]  first_idx_c;
    logic [LEN_W-1:0]  nxt_idx_c;
    logic [NUM_SS-1:0] ss_dec_c;
    logic [DATA_W-1:0] rx_mask_c;
    logic [DATA_W-1:0] rx_rev_c;
    logic [DATA_W-1:0] rx_word_c;

    assign accept_c   = (state == S_IDLE) && bus.wrt;
    assign last_bit_c = (bit_cnt == len_q);
    assign mode_d     = accept_c ? bus.mode : mode_q;

`ifdef SPI_MNRCH_LSB_FIRST_EN
    assign lsb_d = accept_c ? bus.lsb_first : lsb_q;
`else
    assign lsb_d = 1'b0;
`endif

    // Transmit bit index for the first bit and for the bit after the current shift
    assign first_idx_c = lsb_d ? '0 : bus.len;
    assign nxt_idx_c   = lsb_q ? (bit_cnt + LEN_W'(1)) : (len_q - bit_cnt - LEN_W'(1));

    // Out-of-range serf index leaves every select high
    assign ss_dec_c = (32'(bus.ss_sel) < NUM_SS) ? ~(NUM_SS'(1) << bus.ss_sel) : '1;

    // Received word: first bit lands at bit len (MSB-first) or bit 0 (LSB-first)
    assign rx_mask_c = (DATA_W'(2) << len_q) - DATA_W'(1);
    assign rx_rev_c  = {<<{rx_sr}};
    assign rx_word_c = (lsb_q ? (rx_rev_c >> (LEN_W'(DATA_W - 1) - len_q)) : rx_sr) & rx_mask_c;

    spi_sclk_gen #(.DIV(DIV)) u_sclk_gen (
        .clk         (clk),
        .rst         (rst),
        .state       (state),
        .last_bit    (last_bit_c),
        .mode        (mode_d),
        .smpl_c      (smpl_c),
        .shft_c      (shft_c),
        .porch_end_c (porch_end_c),
        .sclk        (SCLK)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (bus.wrt) state_d = S_FRONT;
            S_FRONT: if (porch_end_c) state_d = S_XFER;
            S_XFER:  if (shft_c && last_bit_c) state_d = S_BACK;
            S_BACK:  if (porch_end_c) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: latch on acceptance, sample mid-bit, shift at bit end, publish at frame end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_q      <= '0;
            len_q     <= '0;
            mode_q    <= '0;
            lsb_q     <= 1'b0;
            bit_cnt   <= '0;
            rx_sr     <= '0;
            miso_smpl <= 1'b0;
            SS_n      <= '1;
            MOSI      <= 1'b0;
            rd_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            mode_q <= mode_d;
            lsb_q  <= lsb_d;
            if (accept_c) begin
                tx_q    <= bus.wt_data;
                len_q   <= bus.len;
                bit_cnt <= '0;
                rx_sr   <= '0;
                SS_n    <= ss_dec_c;
                MOSI    <= bus.wt_data[first_idx_c];
                busy_q  <= 1'b1;
                done_q  <= 1'b0;
            end
            if (smpl_c)
                miso_smpl <= MISO;
            if (shft_c) begin
                rx_sr <= {rx_sr[DATA_W-2:0], miso_smpl};
                if (last_bit_c) begin
                    MOSI <= 1'b0;
                end else begin
                    bit_cnt <= bit_cnt + LEN_W'(1);
                    MOSI    <= tx_q[nxt_idx_c];
                end
            end
            if (state == S_BACK && porch_end_c) begin
                rd_q   <= rx_word_c;
                SS_n   <= '1;
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

    assign bus.rd_data = rd_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_spi_mnrch_param.sv
// Scoreboard bench for spi_mnrch_param: a mode-aware serf model plus a done monitor.
module tb_spi_mnrch_param;
    import spi_mnrch_pkg::*;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned NUM_SS = 4;
    localparam int unsigned DIV    = 16;

    typedef struct {
        logic [15:0] wt;
        logic [15:0] mw;
        int          len;
        logic        cpol;
        logic        cpha;
        int          sel;
        logic        lsb;
    } frame_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              MISO = 1'b0;
    logic [NUM_SS-1:0] SS_n;
    logic              SCLK;
    logic              MOSI;

    spi_mnrch_if #(.DATA_W(DATA_W), .NUM_SS(NUM_SS)) bus ();

    spi_mnrch_param #(.DATA_W(DATA_W), .NUM_SS(NUM_SS), .DIV(DIV)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .MISO (MISO),
        .SS_n (SS_n),
        .SCLK (SCLK),
        .MOSI (MOSI)
    );

    always #5 clk = ~clk;

    int     n_vec = 0;
    int     n_err = 0;
    frame_t frm_q[$];
    frame_t exp_q[$];
    int     exp_done = 0;
    int     done_rises = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // k-th bit on the wire of a frame, in transmission order
    function automatic logic bitk(input logic [15:0] w, input int len, input logic lsb, input int k);
        logic [15:0] t;
        t = w >> (lsb ? k : len - k);
        return t[0];
    endfunction

    function automatic logic [31:0] wire_word(input frame_t f);
        logic [31:0] e;
        e = 0;
        for (int k = 0; k <= f.len; k++) e = (e << 1) | 32'(bitk(f.wt, f.len, f.lsb, k));
        return e;
    endfunction

    function automatic frame_t mk(input logic [15:0] wt, input logic [15:0] mw, input int len,
                                  input int mode, input int sel, input logic lsb);
        frame_t f;
        f.wt = wt; f.mw = mw; f.len = len;
        f.cpol = 1'((mode >> 1) & 1); f.cpha = 1'(mode & 1);
        f.sel = sel; f.lsb = lsb;
        return f;
    endfunction

    // Serf model: samples MOSI on the mid-bit SCLK edge, launches MISO on the other edge
    logic              act_prev = 1'b0;
    logic              sclk_prev = 1'b0;
    logic              ss_bad = 1'b0;
    logic [NUM_SS-1:0] ss_fall = '1;
    frame_t            cur;
    int                low_cnt = 0, n_rise = 0, n_out = 0;
    logic [31:0]       cap = 0;

    always @(negedge clk) begin
        logic act;
        logic [NUM_SS-1:0] ss_exp;
        act = (SS_n != '1);
        if (rst) begin
            act_prev = 1'b0;
        end else begin
            if (act && !act_prev) begin
                if (frm_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL frame_queue: SS_n fell with no frame issued");
                    cur = mk(0, 0, 0, 0, 0, 0);
                end else begin
                    cur = frm_q.pop_front();
                end
                low_cnt = 0; n_rise = 0; cap = 0; ss_bad = 1'b0; ss_fall = SS_n;
                ss_exp = ~(NUM_SS'(1) << cur.sel);
                check("ss_pattern", 32'(SS_n), 32'(ss_exp));
                check("sclk_idle_pre", 32'(SCLK), 32'(cur.cpol));
                check("busy_in_frame", 32'(bus.busy), 32'd1);
                check("done_cleared", 32'(bus.done), 32'd0);
                sclk_prev = SCLK;
                if (!cur.cpha) begin
                    MISO = bitk(cur.mw, cur.len, cur.lsb, 0);
                    n_out = 1;
                end else begin
                    n_out = 0;
                end
            end
            if (act) begin
                low_cnt++;
                if (SS_n != ss_fall) ss_bad = 1'b1;
                if (SCLK != sclk_prev) begin
                    if (SCLK) n_rise++;
                    if (SCLK == (cur.cpol == cur.cpha)) begin
                        cap = (cap << 1) | 32'(MOSI);
                    end else if (n_out <= cur.len) begin
                        MISO = bitk(cur.mw, cur.len, cur.lsb, n_out);
                        n_out++;
                    end
                end
                sclk_prev = SCLK;
            end
            if (!act && act_prev) begin
                check("ss_low_clks", 32'(low_cnt), 32'((cur.len + 1) * DIV + DIV));
                check("ss_stable", 32'(ss_bad), 32'd0);
                check("sclk_rises", 32'(n_rise), 32'(cur.len + 1));
                check("mosi_bits", cap, wire_word(cur));
                check("sclk_idle_post", 32'(SCLK), 32'(cur.cpol));
            end
            act_prev = act;
        end
    end

    // Done monitor: every done rise retires one expected frame
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        frame_t f;
        logic [31:0] m;
        if (rst) begin
            done_prev = 1'b0;
        end else begin
            if (bus.done && !done_prev) begin
                done_rises++;
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL done_unexpected: done rose with no frame pending");
                end else begin
                    f = exp_q.pop_front();
                    m = (32'd1 << (f.len + 1)) - 32'd1;
                    check("rd_data", 32'(bus.rd_data), 32'(f.mw) & m);
                    check("busy_at_done", 32'(bus.busy), 32'd0);
                    check("sclk_idle_done", 32'(SCLK), 32'(f.cpol));
                end
            end
            done_prev = bus.done;
        end
    end

    task automatic start(input frame_t f);
        frm_q.push_back(f);
        bus.wt_data = f.wt;
        bus.len     = 4'(f.len);
        bus.mode    = {f.cpol, f.cpha};
        bus.ss_sel  = 2'(f.sel);
`ifdef SPI_MNRCH_LSB_FIRST_EN
        bus.lsb_first = f.lsb;
`endif
        bus.wrt = 1'b1;
        @(posedge clk); #1;
        bus.wrt = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!bus.done && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_seen", 32'(bus.done), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic run(input frame_t f);
        exp_q.push_back(f);
        exp_done++;
        start(f);
        wait_done();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t f;
        logic lsb_r;
        bus.wrt = 1'b0; bus.wt_data = '0; bus.len = '0; bus.mode = '0; bus.ss_sel = '0;
`ifdef SPI_MNRCH_LSB_FIRST_EN
        bus.lsb_first = 1'b0;
`endif
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ss_n", 32'(SS_n), 32'hF);
        check("rst_sclk", 32'(SCLK), 32'd0);
        check("rst_mosi", 32'(MOSI), 32'd0);
        check("rst_rd_data", 32'(bus.rd_data), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        run(mk(16'hA5C3, 16'h3C5A, 15, 3, 0, 1'b0));
        run(mk(16'h0096, 16'h00FF, 7, 0, 2, 1'b0));

        // wrt re-pulsed mid-frame with different inputs must be ignored
        f = mk(16'h1234, 16'hBEEF, 15, 1, 1, 1'b0);
        exp_q.push_back(f);
        exp_done++;
        start(f);
        repeat (49) @(posedge clk);
        #1;
        bus.wt_data = 16'hFFFF; bus.len = 4'd3; bus.mode = 2'b10; bus.ss_sel = 2'd3;
        bus.wrt = 1'b1;
        @(posedge clk); #1;
        bus.wrt = 1'b0;
        wait_done();
        check("one_done_per_frame", 32'(done_rises), 32'(exp_done));

        // Abort in the middle of bit 6
        start(mk(16'hC3A5, 16'h5A5A, 15, 2, 3, 1'b0));
        repeat (DIV / 2 + 6 * DIV + DIV / 4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_ss_n", 32'(SS_n), 32'hF);
        check("abort_rd_data", 32'(bus.rd_data), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort_no_done", 32'(done_rises), 32'(exp_done));
        run(mk(16'h6E21, 16'h9D4B, 11, 1, 1, 1'b0));

        // 1-bit frames in every mode, MISO 0 then 1
        for (int m = 0; m < 4; m++)
            for (int b = 0; b < 2; b++)
                run(mk(16'($urandom_range(0, 1)), 16'(b), 0, m, m, 1'b0));

`ifdef SPI_MNRCH_LSB_FIRST_EN
        run(mk(16'h0001, 16'h0001, 15, 0, 0, 1'b1));
`endif

        for (int i = 0; i < 25; i++) begin
`ifdef SPI_MNRCH_LSB_FIRST_EN
            lsb_r = 1'($urandom_range(0, 1));
`else
            lsb_r = 1'b0;
`endif
            run(mk(16'($urandom), 16'($urandom), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), lsb_r));
        end

        repeat (5) @(posedge clk);
        #1;
        check("done_count", 32'(done_rises), 32'(exp_done));
        check("queues_drained", 32'(exp_q.size() + frm_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
